// File: rtl/seg_disp_arbiter.sv
// -----------------------------------------------------------------------------
// seg_disp_arbiter
//
// Shares one seven-segment display driver between three value sources.
// Requesting sources are served round-robin. Each one holds the display for a
// dwell slot of DWELL_MAX+1 cycles. Between two sources the display is blanked
// for BLANK_MAX+1 cycles so that digits from different sources never mix.
//
// Ports
//   sys_clk      in   1   sole clock, rising edge
//   sys_rst_n    in   1   asynchronous active-low reset
//   req          in   3   per-source display request, bit i = source i
//   data_0..2    in  20   source binary value
//   point_0..2   in   6   source decimal-point mask
//   sign_in      in   3   per-source negative flag, bit i = source i
//   data         out 20   value to the display driver (registered)
//   point        out  6   dot mask to the display driver (registered)
//   sign         out  1   negative flag to the display driver (registered)
//   seg_en       out  1   display enable, high only while a source is shown
//   grant        out  3   one-hot granted source, 0 when idle
// -----------------------------------------------------------------------------
module seg_disp_arbiter #(
    parameter logic [25:0] DWELL_MAX = 26'd49_999_999,
    parameter logic [15:0] BLANK_MAX = 16'd9_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [2:0]  req,
    input  logic [19:0] data_0,
    input  logic [19:0] data_1,
    input  logic [19:0] data_2,
    input  logic [5:0]  point_0,
    input  logic [5:0]  point_1,
    input  logic [5:0]  point_2,
    input  logic [2:0]  sign_in,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic [2:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  grant_next;
    logic [1:0]  last_idx;
    logic [1:0]  last_next;
    logic [15:0] blank_cnt;
    logic [15:0] blank_next;
    logic [25:0] dwell_cnt;
    logic [25:0] dwell_next;
    logic        load_data;

    logic [2:0]  rr_pick;
    logic [1:0]  rr_pick_idx;
    logic        granted_req;
    logic        other_req;

    logic [19:0] sel_data;
    logic [5:0]  sel_point;
    logic        sel_sign;

    // Round-robin search: the first requesting source after the last granted
    // one, wrapping 0->1->2->0. The last granted source itself is checked last,
    // so it only wins again when nobody else is asking.
    function automatic logic [2:0] rr_select(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] pick;
        pick = 3'b000;
        case (last)
            2'd0: begin
                if      (r[1]) pick = 3'b010;
                else if (r[2]) pick = 3'b100;
                else if (r[0]) pick = 3'b001;
            end
            2'd1: begin
                if      (r[2]) pick = 3'b100;
                else if (r[0]) pick = 3'b001;
                else if (r[1]) pick = 3'b010;
            end
            default: begin
                if      (r[0]) pick = 3'b001;
                else if (r[1]) pick = 3'b010;
                else if (r[2]) pick = 3'b100;
            end
        endcase
        return pick;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    assign rr_pick     = rr_select(req, last_idx);
    assign rr_pick_idx = onehot_idx(rr_pick);
    assign granted_req = |(req & grant);
    assign other_req   = |(req & ~grant);
    assign seg_en      = (state == SHOW);

    // Source mux feeding the output registers; follows the current grant.
    always_comb begin
        sel_data  = 20'd0;
        sel_point = 6'd0;
        sel_sign  = 1'b0;
        case (grant)
            3'b001: begin
                sel_data  = data_0;
                sel_point = point_0;
                sel_sign  = sign_in[0];
            end
            3'b010: begin
                sel_data  = data_1;
                sel_point = point_1;
                sel_sign  = sign_in[1];
            end
            3'b100: begin
                sel_data  = data_2;
                sel_point = point_2;
                sel_sign  = sign_in[2];
            end
            default: begin
            end
        endcase
    end

    // Next-state logic. Counters default to zero so that every state entry
    // starts them fresh; they only advance while staying in the same state and
    // stop at their MAX, where the state always makes a decision.
    // The output registers are loaded whenever the next state is SHOW, which
    // gives a valid value already in the first SHOW cycle and a one-cycle
    // tracking latency afterwards. A dropped request on the granted source
    // takes priority over the dwell count.
    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last_idx;
        blank_next = 16'd0;
        dwell_next = 26'd0;
        load_data  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = BLANK;
                    grant_next = rr_pick;
                    last_next  = rr_pick_idx;
                end
            end
            BLANK: begin
                if (blank_cnt != BLANK_MAX) begin
                    blank_next = blank_cnt + 16'd1;
                end else if (granted_req) begin
                    state_next = SHOW;
                    load_data  = 1'b1;
                end else if (|req) begin
                    state_next = BLANK;
                    grant_next = rr_pick;
                    last_next  = rr_pick_idx;
                end else begin
                    state_next = IDLE;
                    grant_next = 3'b000;
                end
            end
            SHOW: begin
                if (!granted_req) begin
                    if (|req) begin
                        state_next = BLANK;
                        grant_next = rr_pick;
                        last_next  = rr_pick_idx;
                    end else begin
                        state_next = IDLE;
                        grant_next = 3'b000;
                    end
                end else if (dwell_cnt != DWELL_MAX) begin
                    dwell_next = dwell_cnt + 26'd1;
                    load_data  = 1'b1;
                end else if (other_req) begin
                    state_next = BLANK;
                    grant_next = rr_pick;
                    last_next  = rr_pick_idx;
                end else begin
                    load_data  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 3'b000;
            end
        endcase
    end

    // State, arbitration and output registers. The last-granted pointer resets
    // to source 2 so that source 0 is the first one served.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            grant     <= 3'b000;
            last_idx  <= 2'd2;
            blank_cnt <= 16'd0;
            dwell_cnt <= 26'd0;
            data      <= 20'd0;
            point     <= 6'd0;
            sign      <= 1'b0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            last_idx  <= last_next;
            blank_cnt <= blank_next;
            dwell_cnt <= dwell_next;
            if (load_data) begin
                data  <= sel_data;
                point <= sel_point;
                sign  <= sel_sign;
            end
        end
    end

endmodule
